// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// pll_lock_supervisor: sequences PLL reset, qualifies lock, retries on timeout
// and holds downstream logic in reset until lock is stable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 7,
  parameter int RETRY_W             = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic [7:0]         lock_loss_cnt
);

  localparam int c_PULSE_W = $clog2(RST_PULSE_CYCLES + 1);
  localparam int c_WAIT_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int c_STAB_W  = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [c_PULSE_W-1:0] c_PULSE_LAST = c_PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_STAB_W-1:0]  c_STAB_DONE  = c_STAB_W'(LOCK_STABLE_CYCLES);
  localparam logic [RETRY_W-1:0]   c_RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  localparam logic [2:0] c_ST_PULSE = 3'd0;
  localparam logic [2:0] c_ST_WAIT  = 3'd1;
  localparam logic [2:0] c_ST_STAB  = 3'd2;
  localparam logic [2:0] c_ST_RUN   = 3'd3;
  localparam logic [2:0] c_ST_FAIL  = 3'd4;

  logic [2:0]           r_state;
  logic [1:0]           r_sync;
  logic [c_PULSE_W-1:0] r_pulse_cnt;
  logic [c_WAIT_W-1:0]  r_wait_cnt;
  logic [c_STAB_W-1:0]  r_stab_cnt;
  logic                 r_pll_rst;
  logic                 r_sys_rst;
  logic                 r_ready;
  logic                 r_fail;
  logic [RETRY_W-1:0]   r_retry;
  logic [7:0]           r_loss;
  logic                 w_lock_s;

  assign w_lock_s      = r_sync[1];
  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign fail          = r_fail;
  assign retry_count   = r_retry;
  assign lock_loss_cnt = r_loss;

  // Outputs are updated on the same edge as the state transition that implies them.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_PULSE;
      r_sync      <= 2'b00;
      r_pulse_cnt <= '0;
      r_wait_cnt  <= '0;
      r_stab_cnt  <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_retry     <= '0;
      r_loss      <= 8'd0;
    end else begin
      r_sync <= {r_sync[0], pll_locked};
      case (r_state)
        c_ST_PULSE: begin
          if (r_pulse_cnt == c_PULSE_LAST) begin
            r_pulse_cnt <= '0;
            r_wait_cnt  <= '0;
            r_pll_rst   <= 1'b0;
            r_state     <= c_ST_WAIT;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + c_PULSE_W'(1);
          end
        end
        c_ST_WAIT: begin
          // Lock takes priority over a coincident timeout.
          if (w_lock_s) begin
            r_stab_cnt <= c_STAB_W'(1);
            r_wait_cnt <= '0;
            r_state    <= c_ST_STAB;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_wait_cnt  <= '0;
            r_pll_rst   <= 1'b1;
            r_pulse_cnt <= '0;
            if (r_retry == c_RETRY_MAX) begin
              r_fail  <= 1'b1;
              r_state <= c_ST_FAIL;
            end else begin
              r_retry <= r_retry + RETRY_W'(1);
              r_state <= c_ST_PULSE;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
          end
        end
        c_ST_STAB: begin
          if (!w_lock_s) begin
            r_wait_cnt <= '0;
            r_state    <= c_ST_WAIT;
          end else if (r_stab_cnt == c_STAB_DONE) begin
            r_sys_rst <= 1'b0;
            r_ready   <= 1'b1;
            r_retry   <= '0;
            r_state   <= c_ST_RUN;
          end else begin
            r_stab_cnt <= r_stab_cnt + c_STAB_W'(1);
          end
        end
        c_ST_RUN: begin
          if (!w_lock_s || relock_req) begin
            r_pulse_cnt <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_state     <= c_ST_PULSE;
            if (!w_lock_s && (r_loss != 8'hFF)) begin
              r_loss <= r_loss + 8'd1;
            end
          end
        end
        c_ST_FAIL: begin
          if (relock_req) begin
            r_pulse_cnt <= '0;
            r_fail      <= 1'b0;
            r_retry     <= '0;
            r_state     <= c_ST_PULSE;
          end
        end
        default: begin
          r_pulse_cnt <= '0;
          r_pll_rst   <= 1'b1;
          r_sys_rst   <= 1'b1;
          r_ready     <= 1'b0;
          r_fail      <= 1'b0;
          r_state     <= c_ST_PULSE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// tb_pll_lock_supervisor: table-driven directed bench for pll_lock_supervisor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [2:0] retry_count;
  logic [7:0] lock_loss_cnt;

  int checks   = 0;
  int failures = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2),
    .RETRY_W            (3)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fail         (fail),
    .retry_count  (retry_count),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    string      name;
    int         edges;
    logic       rst_v;
    logic       locked;
    logic       relock;
    logic       e_pll_rst;
    logic       e_sys_rst;
    logic       e_ready;
    logic       e_fail;
    logic [2:0] e_retry;
    logic [7:0] e_loss;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input int ed, input logic r, input logic lk,
                     input logic rq, input logic ep, input logic es, input logic er,
                     input logic ef, input logic [2:0] rc, input logic [7:0] ll);
    vec_t v;
    v.name = nm; v.edges = ed; v.rst_v = r; v.locked = lk; v.relock = rq;
    v.e_pll_rst = ep; v.e_sys_rst = es; v.e_ready = er; v.e_fail = ef;
    v.e_retry = rc; v.e_loss = ll;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Drop lock for three cycles in RUN, then restore it and wait for RUN again.
  task automatic lose_once(input bit detail);
    int n;
    pll_locked = 1'b0;
    tick();
    if (detail) chk("loss_d0_sys_rst", 8'(sys_rst), 8'd0);
    tick();
    if (detail) chk("loss_d1_ready", 8'(ready), 8'd1);
    tick();
    if (detail) begin
      chk("loss_d2_sys_rst", 8'(sys_rst), 8'd1);
      chk("loss_d2_pll_rst", 8'(pll_rst), 8'd1);
    end
    pll_locked = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (detail) chk("loss_pulse_len", 8'(n), 8'd4);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("loss_relock_ready", 8'(ready), 8'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    tick();

    // name, edges, rst, locked, relock | pll_rst, sys_rst, ready, fail, retry, loss
    // No lock: three attempts, then FAIL; relock_req from FAIL; relock_req ignored in WAIT.
    add("a_reset",        0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add("a_release",      0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("a_e3",           3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("a_e4",           1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("a_e35",         31, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("a_e36",          1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    add("a_e39",          3, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    add("a_e40",          1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add("a_e72",         32, 0, 0, 0, 1, 1, 0, 0, 2, 0);
    add("a_e76",          4, 0, 0, 0, 0, 1, 0, 0, 2, 0);
    add("a_e107",        31, 0, 0, 0, 0, 1, 0, 0, 2, 0);
    add("a_e108",         1, 0, 0, 0, 1, 1, 0, 1, 2, 0);
    add("a_e150",        42, 0, 0, 0, 1, 1, 0, 1, 2, 0);
    add("a_fail_relock",  1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add("a_rp3",          3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("a_rp4",          1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("a_wait_relock",  1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add("a_wait31",      30, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("a_wait32",       1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    // Clean lock, then a lock loss in RUN.
    add("b_reset",        0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add("b_release",      0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("b_e10",         10, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("b_e19",          9, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("b_e20",          1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("b_e21",          1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add("b_drop_e23",     2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add("b_drop_e24",     1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add("b_e27",          3, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    add("b_e28",          1, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add("b_e36",          8, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add("b_e37",          1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    // Unstable lock in STAB, loss+relock together, relock in RUN, reset mid-STAB.
    add("c_reset",        0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add("c_release",      0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add("c_e10",         10, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("c_e15",          5, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("c_e16",          1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add("c_e18",          2, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("c_e22",          4, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("c_e26",          4, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("c_e27",          1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add("c_e29",          2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add("c_both_e30",     1, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add("c_e33",          3, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    add("c_e34",          1, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add("c_e36",          2, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add("c_e42",          6, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add("c_e43",          1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    add("c_relock_run",   1, 0, 1, 1, 1, 1, 0, 0, 0, 1);
    add("c_e48",          4, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add("c_e50_stab",     2, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add("c_async_rst",    0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    add("c_release2",     0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add("c_r4",           4, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("c_r12",          8, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add("c_r13",          1, 0, 1, 0, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      rst        = vecs[i].rst_v;
      pll_locked = vecs[i].locked;
      relock_req = vecs[i].relock;
      if (vecs[i].edges == 0) #1;
      else repeat (vecs[i].edges) tick();
      chk({vecs[i].name, ".pll_rst"}, 8'(pll_rst),     8'(vecs[i].e_pll_rst));
      chk({vecs[i].name, ".sys_rst"}, 8'(sys_rst),     8'(vecs[i].e_sys_rst));
      chk({vecs[i].name, ".ready"},   8'(ready),       8'(vecs[i].e_ready));
      chk({vecs[i].name, ".fail"},    8'(fail),        8'(vecs[i].e_fail));
      chk({vecs[i].name, ".retry"},   8'(retry_count), 8'(vecs[i].e_retry));
      chk({vecs[i].name, ".loss"},    8'(lock_loss_cnt), vecs[i].e_loss);
    end
    relock_req = 1'b0;

    // Three detailed lock losses from RUN, then drive the counter into saturation.
    for (int k = 0; k < 3; k++) lose_once(1'b1);
    chk("loss_cnt_3", lock_loss_cnt, 8'd3);
    chk("run_retry_zero", 8'(retry_count), 8'd0);
    for (int k = 0; k < 257; k++) lose_once(1'b0);
    chk("loss_cnt_sat", lock_loss_cnt, 8'd255);
    chk("sat_ready", 8'(ready), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Control-side counterpart to the video PLL: drives the PLL reset input and consumes its asynchronous `locked` output.
- Sequences the PLL reset pulse, qualifies lock, retries on timeout, and holds downstream logic in reset until lock is stable.
- On lock loss, re-arms the PLL and counts loss events for status readback.
- Runs on the free-running reference clock that feeds the PLL.

Parameters:
- RST_PULSE_CYCLES, 16: number of refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024: number of consecutive synchronized-lock samples required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: number of refclk cycles to wait for lock per attempt (>=1).
- MAX_RETRIES, 7: number of re-attempts after the first timeout; total attempts = MAX_RETRIES+1.
- RETRY_W, 3: width of retry_count; must hold MAX_RETRIES.

Ports:
- refclk  in  1  free-running reference clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock indicator; asynchronous to refclk.
- relock_req  in  1  synchronous single-cycle request to force a new lock sequence.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  downstream reset, active-high.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_count  out  RETRY_W  timeouts in the current sequence.
- lock_loss_cnt  out  8  lock losses seen in RUN; saturating.

Behaviour:
- Reset (rst=1, async):
  - State = PULSE, cycle counter = 0, synchronizer flops = 0.
  - pll_rst=1, sys_rst=1, ready=0, fail=0, retry_count=0, lock_loss_cnt=0.
- Lock synchronizer: pll_locked passes through 2 flops to give lock_s. Latency is 2 edges; no other filtering.
- All outputs are registered. Each output takes its new value on the same edge as the state change that drives it.
- PULSE:
  - pll_rst=1, sys_rst=1.
  - Counter counts RST_PULSE_CYCLES edges, then clears and moves to WAIT.
  - pll_rst is high for exactly RST_PULSE_CYCLES cycles per attempt.
- WAIT:
  - pll_rst=0, sys_rst=1. Counter counts cycles.
  - If lock_s=1: go to STAB with stable count = 1.
  - Else, if the counter reaches LOCK_TIMEOUT_CYCLES:
    - If retry_count == MAX_RETRIES: go to FAIL.
    - Otherwise: retry_count+1 and go to PULSE.
  - If lock and timeout occur in the same cycle, lock wins.
- STAB:
  - pll_rst=0, sys_rst=1.
  - lock_s=1: stable count +1. When it reaches LOCK_STABLE_CYCLES, go to RUN.
  - lock_s=0: go to WAIT. The timeout counter restarts at 0; retry_count is unchanged.
  - ready and sys_rst change exactly 2+LOCK_STABLE_CYCLES edges after the first edge sampling pll_locked=1, provided pll_locked stays high.
- RUN:
  - sys_rst=0, ready=1, retry_count cleared to 0.
  - lock_s=0: go to PULSE (sys_rst=1, ready=0 on that edge) and lock_loss_cnt+1, saturating at 255.
  - relock_req=1: go to PULSE with no count.
  - Both in the same cycle: a single PULSE entry, and lock_loss_cnt increments once.
- FAIL:
  - pll_rst=1, sys_rst=1, fail=1. Held until rst or relock_req.
  - relock_req: go to PULSE, with fail=0 and retry_count=0.
- relock_req is ignored in PULSE, WAIT and STAB.
- A pll_locked glitch shorter than 1 cycle may or may not be sampled. If sampled, it is treated as a real transition.
- Reset mid-operation: rst returns every output to its reset value immediately, regardless of state.
- Counter widths:
  - Each counter is sized with $clog2(max+1) of its own parameter.
  - No wrap is possible: counters compare against their terminal count and clear.

Test Plan (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2):
- Clean lock: release rst, raise pll_locked 10 cycles later and hold it.
  - pll_rst is high for exactly 4 cycles.
  - ready=1 and sys_rst=0 exactly 10 edges after pll_locked is first sampled high.
  - retry_count=0.
- No lock: hold pll_locked=0.
  - 3 pll_rst pulses of 4 cycles each.
  - retry_count steps 0,1,2.
  - fail=1 at edge 108 after rst release; pll_rst stays 1 thereafter.
- Unstable lock: in STAB, drop pll_locked after 5 high cycles, then hold it high.
  - State returns to WAIT and ready stays 0.
  - ready rises 10 edges after the second rise.
  - No extra pll_rst pulse.
- Lock loss in RUN: drop pll_locked for 3 cycles, 3 times, each after re-lock.
  - Each loss asserts sys_rst 2 edges after the drop and gives a 4-cycle pll_rst pulse.
  - lock_loss_cnt=3.
  - Force 260 losses → lock_loss_cnt=255.
- relock_req paths:
  - In FAIL: pulse relock_req → fail=0, retry_count=0, pll_rst pulse restarts.
  - Pulse in WAIT → ignored.
  - Same cycle as a lock loss in RUN → one pll_rst pulse, lock_loss_cnt +1.
- Async reset mid-STAB: assert rst between edges → all outputs at reset values before the next edge; a clean sequence resumes after release.
